mac_pipe_acc: RTL and testbench
===============================

MAC_PIPE_ACC -- requirements
Module: mac_pipe_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits.
REQ-002 SHALL have parameter ACC_WIDTH, default 2*WIDTH+8: accumulator and result width; legal range is at least 2*WIDTH.
REQ-003 SHALL have parameter SIGNED, default 0: 1 means two's-complement operands and accumulator; 0 means unsigned.
REQ-004 SHALL have parameter SATURATE, default 0: 1 means clip at the accumulator limits; 0 means wrap modulo 2^ACC_WIDTH.
REQ-005 SHALL have parameter CNT_WIDTH, default 8: width of the term counter.
REQ-006 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all logic on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input beat offered.
- in_ready, out, 1, input beat can be accepted.
- a, in, WIDTH, multiplicand.
- b, in, WIDTH, multiplier.
- first, in, 1, beat starts a new dot product.
- last, in, 1, beat ends the dot product.
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer accepts the result.
- result, out, ACC_WIDTH, accumulated dot product.
- overflow, out, 1, overflow or clip occurred within this dot product.
- count, out, CNT_WIDTH, number of terms in the result.

Function
REQ-007 SHALL accept a beat only when in_valid and in_ready are both high.
REQ-008 SHALL define stall = out_valid AND NOT out_ready; in_ready SHALL equal NOT stall, combinationally.
REQ-009 SHALL implement a 2-stage pipeline that freezes entirely while stall is high; no beat is lost or duplicated.
- Stage 1 registers the full-precision product (2*WIDTH bits) together with the beat's valid, first and last.
- Stage 2 updates the accumulator.
REQ-010 SHALL sign-extend the product to ACC_WIDTH when SIGNED=1 and zero-extend it when SIGNED=0.
REQ-011 Stage 2 SHALL compute acc_next as follows:
- first=1: acc_next = product; overflow flag and term count restart.
- otherwise: acc_next = acc + product.
REQ-012 SHALL, when SATURATE=1, clip acc_next to the maximum or minimum representable value (signed or unsigned per SIGNED) and set the sticky overflow flag.
REQ-013 SHALL, when SATURATE=0, wrap acc_next modulo 2^ACC_WIDTH and set the sticky overflow flag on a carry-out (unsigned) or sign overflow (signed).
REQ-014 SHALL increment the term counter once per stage-2 beat, saturating at 2^CNT_WIDTH-1.
REQ-015 SHALL, when a stage-2 beat has last=1:
- load result, overflow and count with that beat's values;
- set out_valid on the next edge;
- clear the accumulator, flag and counter so that a following beat without first starts from 0.
REQ-016 SHALL have a latency of 2 cycles: a last beat accepted at edge n gives out_valid=1 after edge n+2 when there is no stall.
REQ-017 SHALL, when out_valid and out_ready are both high, retire the result on that edge. A new result arriving on the same edge SHALL replace it, keeping out_valid=1; otherwise out_valid SHALL clear.
REQ-018 SHALL hold result, overflow and count stable while out_valid=1 and out_ready=0.
REQ-019 SHALL treat first=1 and last=1 on the same beat as a one-term dot product.
REQ-020 SHALL accept a first beat arriving mid-accumulation (no preceding last): the partial sum is discarded and no result is emitted for it.
REQ-021 SHALL allow a sustained throughput of one beat per cycle while out_ready=1.

Reset
REQ-022 SHALL, on rst_n low, asynchronously clear:
- both pipeline valids, the accumulator, the overflow flag and the term counter;
- out_valid=0, result=0, overflow=0, count=0.
REQ-023 SHALL drive in_ready=1 during reset and after reset release.
REQ-024 SHALL discard any dot product in flight when reset is asserted mid-operation; no partial result is emitted afterwards.

Structure
REQ-025 SHALL take its default width constants from the shared package mac_pkg.
REQ-026 SHALL place the saturating/wrapping add and overflow detection in one sub-module, mac_sat_add, parametrised by ACC_WIDTH, SIGNED and SATURATE.

Verification
REQ-027 SHALL cover (WIDTH=8, ACC_WIDTH=24, unsigned): beats (3,4,first), (5,6), (7,8,last) -> result=98, count=3, overflow=0, out_valid=1 two cycles after the last beat.
REQ-028 SHALL cover: a=255, b=255 with first=last=1 -> result=65025, count=1; back-to-back single-term beats produce one result per cycle.
REQ-029 SHALL cover SIGNED=1: beats (-128,127,first), (-128,127,last) -> result=-32512, overflow=0.
REQ-030 SHALL cover ACC_WIDTH=16, unsigned, beats (255,255,first), (255,255,last):
- SATURATE=1 -> result=65535, overflow=1;
- SATURATE=0 -> result=64514, overflow=1.
REQ-031 SHALL cover backpressure: out_ready=0 for 5 cycles with a result pending -> in_ready=0, result stable, no beats lost; after out_ready=1 the next results are bit-exact.
REQ-032 SHALL cover reset mid-operation: rst_n pulsed low between beat 2 and the last beat -> no out_valid; the next (first, last) beat (2,3) -> result=6, count=1.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared width defaults for the pipelined multiply-accumulate block.
package mac_pkg;

  localparam int MAC_WIDTH     = 8;
  localparam int MAC_ACC_GUARD = 8;
  localparam int MAC_CNT_WIDTH = 8;

endpackage

// File: rtl/mac_sat_add.sv
// Accumulator adder: full add, overflow detection, then clip or wrap.
module mac_sat_add #(
  parameter int ACC_WIDTH = 24,
  parameter int SIGNED    = 0,
  parameter int SATURATE  = 0
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [ACC_WIDTH-1:0] addend,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 ovf
);

  logic [ACC_WIDTH:0]   full_s;
  logic [ACC_WIDTH-1:0] max_s;
  logic [ACC_WIDTH-1:0] min_s;

  // Add, flag overflow and select the clipped or wrapped sum
  always_comb begin
    full_s = {1'b0, acc} + {1'b0, addend};
    if (SIGNED != 0) begin
      max_s = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      min_s = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      ovf   = (acc[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
              (full_s[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    end else begin
      max_s = {ACC_WIDTH{1'b1}};
      min_s = {ACC_WIDTH{1'b0}};
      ovf   = full_s[ACC_WIDTH];
    end
    // Unsigned overflow only goes upward; signed overflow follows the operand sign
    if ((SATURATE != 0) && ovf) begin
      sum = ((SIGNED != 0) && acc[ACC_WIDTH-1]) ? min_s : max_s;
    end else begin
      sum = full_s[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mac_pipe_acc.sv
// Two-stage multiply-accumulate pipeline producing one dot product per last beat,
// with a registered result stage that stalls the whole pipe under backpressure.
module mac_pipe_acc
  import mac_pkg::*;
#(
  parameter int WIDTH     = MAC_WIDTH,
  parameter int ACC_WIDTH = 2*WIDTH+MAC_ACC_GUARD,
  parameter int SIGNED    = 0,
  parameter int SATURATE  = 0,
  parameter int CNT_WIDTH = MAC_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 first,
  input  logic                 last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int PW = 2*WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 stall_s;
  logic [PW-1:0]        a_ext_s, b_ext_s, prod_s;
  logic                 v1_r, f1_r, l1_r;
  logic [PW-1:0]        p1_r;
  logic                 v2_r, l2_r, flag_r;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 out_valid_r, overflow_r;
  logic [ACC_WIDTH-1:0] result_r;
  logic [CNT_WIDTH-1:0] count_r;
  logic                 clear_s, restart_s, base_flag_s, add_ovf_s;
  logic [ACC_WIDTH-1:0] base_acc_s, prod_ext_s, sum_s;
  logic [CNT_WIDTH-1:0] base_cnt_s, cnt_next_s;

  assign stall_s  = out_valid_r & ~out_ready;
  assign in_ready = ~stall_s;

  // Operand extension; the low PW bits of the product are exact in both modes
  always_comb begin
    if (SIGNED != 0) begin
      a_ext_s = {{WIDTH{a[WIDTH-1]}}, a};
      b_ext_s = {{WIDTH{b[WIDTH-1]}}, b};
    end else begin
      a_ext_s = {{WIDTH{1'b0}}, a};
      b_ext_s = {{WIDTH{1'b0}}, b};
    end
    prod_s = a_ext_s * b_ext_s;
  end

  // Stage 1: product register with beat qualifiers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      f1_r <= 1'b0;
      l1_r <= 1'b0;
      p1_r <= {PW{1'b0}};
    end else if (!stall_s) begin
      v1_r <= in_valid;
      f1_r <= first;
      l1_r <= last;
      p1_r <= prod_s;
    end
  end

  // Stage 2 next state; a retiring last beat makes the next beat start from zero
  always_comb begin
    prod_ext_s           = {ACC_WIDTH{(SIGNED != 0) & p1_r[PW-1]}};
    prod_ext_s[PW-1:0]   = p1_r;
    clear_s              = v2_r & l2_r;
    restart_s            = f1_r | clear_s;
    if (restart_s) begin
      base_acc_s  = {ACC_WIDTH{1'b0}};
      base_flag_s = 1'b0;
      base_cnt_s  = {CNT_WIDTH{1'b0}};
    end else begin
      base_acc_s  = acc_r;
      base_flag_s = flag_r;
      base_cnt_s  = cnt_r;
    end
    cnt_next_s = (base_cnt_s == CNT_MAX) ? CNT_MAX : base_cnt_s + CNT_ONE;
  end

  mac_sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .SIGNED    (SIGNED),
    .SATURATE  (SATURATE)
  ) u_add (
    .acc    (base_acc_s),
    .addend (prod_ext_s),
    .sum    (sum_s),
    .ovf    (add_ovf_s)
  );

  // Stage 2: accumulator, sticky flag and term counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r   <= 1'b0;
      l2_r   <= 1'b0;
      acc_r  <= {ACC_WIDTH{1'b0}};
      flag_r <= 1'b0;
      cnt_r  <= {CNT_WIDTH{1'b0}};
    end else if (!stall_s) begin
      v2_r <= v1_r;
      l2_r <= l1_r;
      if (v1_r) begin
        acc_r  <= sum_s;
        flag_r <= base_flag_s | add_ovf_s;
        cnt_r  <= cnt_next_s;
      end else if (clear_s) begin
        acc_r  <= {ACC_WIDTH{1'b0}};
        flag_r <= 1'b0;
        cnt_r  <= {CNT_WIDTH{1'b0}};
      end
    end
  end

  // Result register: loads on a retiring last beat, holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= {ACC_WIDTH{1'b0}};
      overflow_r  <= 1'b0;
      count_r     <= {CNT_WIDTH{1'b0}};
    end else if (!stall_s) begin
      out_valid_r <= clear_s;
      if (clear_s) begin
        result_r   <= acc_r;
        overflow_r <= flag_r;
        count_r    <= cnt_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign overflow  = overflow_r;
  assign count     = count_r;

endmodule

// File: tb/tb_mac_pipe_acc.sv
// Self-checking bench: five parameter variants share one stimulus stream and are
// checked every cycle against a dot-product model plus hand-computed results.
module tb_mac_pipe_acc;

  localparam int NCFG = 5;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, out_ready, first, last;
  logic [7:0] a, b;

  logic [23:0] res_w  [NCFG];
  logic        ov_w   [NCFG];
  logic        oval_w [NCFG];
  logic        ir_w   [NCFG];
  logic [7:0]  cnt_w  [NCFG];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Variants: 0 unsigned/24 wrap, 1 signed/24 wrap, 2 unsigned/16 sat,
  // 3 unsigned/16 wrap, 4 signed/16 sat
  function automatic int cfg_aw(input int g);
    return (g < 2) ? 24 : 16;
  endfunction
  function automatic bit cfg_sg(input int g);
    return (g == 1 || g == 4);
  endfunction
  function automatic bit cfg_st(input int g);
    return (g == 2 || g == 4);
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int AW = (g < 2) ? 24 : 16;
    localparam int SG = (g == 1 || g == 4) ? 1 : 0;
    localparam int ST = (g == 2 || g == 4) ? 1 : 0;
    logic [AW-1:0] res;
    logic          ovl, ovf, ir;
    logic [7:0]    cnt;
    mac_pipe_acc #(.WIDTH(8), .ACC_WIDTH(AW), .SIGNED(SG), .SATURATE(ST), .CNT_WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir), .a(a), .b(b),
      .first(first), .last(last), .out_valid(ovl), .out_ready(out_ready),
      .result(res), .overflow(ovf), .count(cnt)
    );
    assign res_w[g]  = 24'(res);
    assign ov_w[g]   = ovf;
    assign oval_w[g] = ovl;
    assign ir_w[g]   = ir;
    assign cnt_w[g]  = cnt;
  end

  task automatic chk(input string name, input int g, input longint got, input longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", name, g, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [23:0] res;
    logic        ov;
    logic [7:0]  cnt;
  } exp_t;
  typedef struct {
    exp_t [NCFG-1:0] v;
    int              k;   // unstalled edges left before the result is visible
  } ent_t;

  ent_t   q[$];
  longint macc [NCFG];
  logic   mflag[NCFG];
  int     mcnt [NCFG];

  function automatic void model_reset();
    q.delete();
    for (int g = 0; g < NCFG; g++) begin
      macc[g] = 0; mflag[g] = 1'b0; mcnt[g] = 0;
    end
  endfunction

  function automatic void model_beat();
    ent_t e;
    e.k = 2;
    for (int g = 0; g < NCFG; g++) begin
      longint p, s, md, hi, lo;
      md = longint'(1) << cfg_aw(g);
      if (cfg_sg(g)) begin
        p  = longint'($signed(a)) * longint'($signed(b));
        hi = md / 2 - 1;
        lo = -(md / 2);
      end else begin
        p  = longint'(a) * longint'(b);
        hi = md - 1;
        lo = 0;
      end
      if (first) begin
        macc[g] = 0; mflag[g] = 1'b0; mcnt[g] = 0;
      end
      s = macc[g] + p;
      if (s > hi || s < lo) begin
        mflag[g] = 1'b1;
        if (cfg_st(g)) s = (s > hi) ? hi : lo;
        else           s = (s > hi) ? s - md : s + md;
      end
      macc[g] = s;
      mcnt[g] = (mcnt[g] < 255) ? mcnt[g] + 1 : 255;
      e.v[g].res = 24'(s & (md - 1));
      e.v[g].ov  = mflag[g];
      e.v[g].cnt = 8'(mcnt[g]);
      if (last) begin
        macc[g] = 0; mflag[g] = 1'b0; mcnt[g] = 0;
      end
    end
    if (last) q.push_back(e);
  endfunction

  // Compare outputs against the model, then advance the model to the next edge
  always @(negedge clk) begin
    logic eo, st;
    if (!rst_n) begin
      model_reset();
      for (int g = 0; g < NCFG; g++) begin
        chk("rst_out_valid", g, oval_w[g], 0);
        chk("rst_result",    g, res_w[g],  0);
        chk("rst_overflow",  g, ov_w[g],   0);
        chk("rst_count",     g, cnt_w[g],  0);
        chk("rst_in_ready",  g, ir_w[g],   1);
      end
    end else begin
      eo = (q.size() > 0) && (q[0].k == 0);
      for (int g = 0; g < NCFG; g++) begin
        chk("out_valid", g, oval_w[g], eo);
        chk("in_ready",  g, ir_w[g],   !(eo && !out_ready));
        if (eo) begin
          chk("result",   g, res_w[g], q[0].v[g].res);
          chk("overflow", g, ov_w[g],  q[0].v[g].ov);
          chk("count",    g, cnt_w[g], q[0].v[g].cnt);
        end
      end
      st = eo && !out_ready;
      if (!st) begin
        if (eo) void'(q.pop_front());
        foreach (q[i]) if (q[i].k > 0) q[i].k--;
        if (in_valid) model_beat();
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic beat(input logic [7:0] ia, input logic [7:0] ib, input logic f, input logic l);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = ia; b = ib; first = f; last = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = ir_w[0];
    end
    if (!ok) chk("beat_accept_timeout", 0, 0, 1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; first = 1'b0; last = 1'b0;
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(7))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      3:       return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h00; b = 8'h00; first = 1'b0; last = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 0, ir_w[0], 1);
    @(posedge clk); #1; rst_n = 1'b1;

    // three-term dot product and its latency
    beat(8'd3, 8'd4, 1'b1, 1'b0); beat(8'd5, 8'd6, 1'b0, 1'b0); beat(8'd7, 8'd8, 1'b0, 1'b1); idle();
    @(negedge clk); @(negedge clk);
    chk("lat_early", 0, oval_w[0], 0);
    @(negedge clk);
    chk("lat_valid", 0, oval_w[0], 1);
    chk("dot3_result", 0, res_w[0], 98);
    chk("dot3_count",  0, cnt_w[0], 3);
    chk("dot3_ovf",    0, ov_w[0],  0);

    // single-term max operands, then back-to-back single-term beats
    beat(8'd255, 8'd255, 1'b1, 1'b1); idle();
    repeat (3) @(negedge clk);
    chk("max_result", 0, res_w[0], 65025);
    chk("max_count",  0, cnt_w[0], 1);
    chk("max_signed", 1, res_w[1], 1);
    beat(8'd1, 8'd2, 1'b1, 1'b1); beat(8'd3, 8'd3, 1'b1, 1'b1); beat(8'd10, 8'd10, 1'b1, 1'b1); idle();
    @(negedge clk); chk("b2b_0", 0, res_w[0], 2);
    @(negedge clk); chk("b2b_1", 0, res_w[0], 9);   chk("b2b_1_valid", 0, oval_w[0], 1);
    @(negedge clk); chk("b2b_2", 0, res_w[0], 100); chk("b2b_2_count", 0, cnt_w[0], 1);

    // signed extremes
    beat(8'h80, 8'h7F, 1'b1, 1'b0); beat(8'h80, 8'h7F, 1'b0, 1'b1); idle();
    repeat (3) @(negedge clk);
    chk("signed_result", 1, res_w[1], 24'hFF8100);
    chk("signed_ovf",    1, ov_w[1],  0);
    chk("signed16_res",  4, res_w[4], 16'h8100);
    chk("unsigned_same", 0, res_w[0], 32512);

    // 16-bit accumulator overflow: clip vs wrap
    beat(8'd255, 8'd255, 1'b1, 1'b0); beat(8'd255, 8'd255, 1'b0, 1'b1); idle();
    repeat (3) @(negedge clk);
    chk("sat_result",  2, res_w[2], 65535);
    chk("sat_ovf",     2, ov_w[2],  1);
    chk("wrap_result", 3, res_w[3], 64514);
    chk("wrap_ovf",    3, ov_w[3],  1);
    chk("wide_result", 0, res_w[0], 130050);
    chk("wide_ovf",    0, ov_w[0],  0);

    // backpressure with a result pending
    @(posedge clk); #1; out_ready = 1'b0;
    fork
      begin
        beat(8'd2, 8'd5, 1'b1, 1'b1); beat(8'd4, 8'd4, 1'b1, 1'b1);
        beat(8'd6, 8'd1, 1'b1, 1'b0); beat(8'd6, 8'd2, 1'b0, 1'b1);
        beat(8'd1, 8'd1, 1'b1, 1'b1); idle();
      end
      begin
        bit          seen;
        int          n;
        logic [23:0] got [4];
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) got[i] = 24'd0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          seen = oval_w[0];
        end
        chk("bp_pending", 0, seen, 1);
        for (int i = 0; i < 5; i++) begin
          chk("bp_in_ready", 0, ir_w[0], 0);
          chk("bp_hold",     0, res_w[0], 10);
          @(negedge clk);
        end
        @(posedge clk); #1; out_ready = 1'b1;
        for (int i = 0; i < 30 && n < 4; i++) begin
          @(negedge clk);
          if (oval_w[0] && out_ready) begin
            got[n] = res_w[0];
            n++;
          end
        end
        chk("bp_n", 0, n, 4);
        chk("bp_r0", 0, got[0], 10);
        chk("bp_r1", 0, got[1], 16);
        chk("bp_r2", 0, got[2], 18);
        chk("bp_r3", 0, got[3], 1);
      end
    join

    // reset in the middle of a dot product
    begin
      bit seen;
      seen = 1'b0;
      beat(8'd1, 8'd1, 1'b1, 1'b0); beat(8'd2, 8'd2, 1'b0, 1'b0);
      @(posedge clk); #1; in_valid = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        seen = seen | oval_w[0];
      end
      chk("rst_no_result", 0, seen, 0);
      beat(8'd2, 8'd3, 1'b1, 1'b1); idle();
      repeat (3) @(negedge clk);
      chk("post_rst_result", 0, res_w[0], 6);
      chk("post_rst_count",  0, cnt_w[0], 1);
    end

    // term counter saturation
    beat(8'd1, 8'd1, 1'b1, 1'b0);
    for (int i = 0; i < 258; i++) beat(8'd1, 8'd1, 1'b0, 1'b0);
    beat(8'd1, 8'd1, 1'b0, 1'b1); idle();
    repeat (3) @(negedge clk);
    chk("long_result", 0, res_w[0], 260);
    chk("long_count",  0, cnt_w[0], 255);

    // randomized traffic with random backpressure and one reset
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst_n     = (c == 1500) ? 1'b0 : 1'b1;
      in_valid  = ($urandom_range(3) != 0);
      a         = pick();
      b         = pick();
      first     = ($urandom_range(5) == 0);
      last      = ($urandom_range(4) == 0);
      out_ready = ($urandom_range(3) != 0);
    end

    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("drain_empty", 0, q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
